// File: rtl/pes_arith_pkg.sv
// Shared definitions for the sequential arithmetic units (pes_seq_mul / pes_seq_div).
//   - state_e   : FSM state encoding shared by the sequential units
//   - DefWidth  : default operand width
//   - DefCntW   : step-counter width for the default operand width
package pes_arith_pkg;

   localparam int unsigned DefWidth = 8;
   localparam int unsigned DefCntW  = $clog2(DefWidth);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/pes_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// then subtract the divisor if it fits.
//   i_p    : current partial remainder (WIDTH+1 bits)
//   i_dbit : dividend bit shifted in this step
//   i_b    : divisor
//   o_p    : next partial remainder
//   o_qbit : quotient bit produced by this step
module pes_div_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH:0]   i_p,
   input  logic             i_dbit,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH:0]   o_p,
   output logic             o_qbit
);

   logic [WIDTH:0] w_t;
   logic [WIDTH:0] w_b_ext;

   always_comb begin
      w_t     = {i_p[WIDTH-1:0], i_dbit};
      w_b_ext = {1'b0, i_b};
      o_qbit  = (w_t >= w_b_ext);
      o_p     = o_qbit ? (w_t - w_b_ext) : w_t;
   end

endmodule

// File: rtl/pes_seq_div.sv
// Sequential restoring divider: one quotient bit per clock, result after WIDTH cycles.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   i_load  : start request, samples i_a / i_b
//   i_a     : dividend (unsigned)
//   i_b     : divisor (unsigned)
//   o_q     : quotient (registered)
//   o_r     : remainder (registered)
//   o_valid : o_q / o_r / o_dbz hold a completed result (level)
//   o_busy  : division in progress
//   o_dbz   : last completed division had a zero divisor
module pes_seq_div
   import pes_arith_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_r,
   output logic             o_valid,
   output logic             o_busy,
   output logic             o_dbz
);

   localparam int unsigned    CntW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [CntW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_d;      // dividend shifts out MSB-first, quotient shifts in at LSB
   logic [WIDTH-1:0] r_b;
   logic [WIDTH:0]   r_p;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic             r_valid;
   logic             r_busy;
   logic             r_dbz;

   logic [WIDTH:0]   w_p_nxt;
   logic             w_qbit;
   logic             w_last;

   pes_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_p    (r_p),
      .i_dbit (r_d[WIDTH-1]),
      .i_b    (r_b),
      .o_p    (w_p_nxt),
      .o_qbit (w_qbit)
   );

   assign w_last = (r_state == StRun) && (r_cnt == LastCnt);

   // A load always wins, so it restarts the operation from any state.
   always_comb begin
      w_state_nxt = r_state;
      if (i_load) begin
         w_state_nxt = StRun;
      end else if (w_last) begin
         w_state_nxt = StDone;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_d     <= '0;
         r_b     <= '0;
         r_p     <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_dbz   <= 1'b0;
      end else if (i_load) begin
         r_d     <= i_a;
         r_b     <= i_b;
         r_p     <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
         r_valid <= 1'b0;
      end else if (r_state == StRun) begin
         r_p   <= w_p_nxt;
         r_d   <= {r_d[WIDTH-2:0], w_qbit};
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_q     <= {r_d[WIDTH-2:0], w_qbit};
            r_r     <= w_p_nxt[WIDTH-1:0];
            r_dbz   <= (r_b == '0);
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
         end
      end
   end

   assign o_q     = r_q;
   assign o_r     = r_r;
   assign o_valid = r_valid;
   assign o_busy  = r_busy;
   assign o_dbz   = r_dbz;

endmodule

// File: doc/pes_seq_div.md
Name: pes_seq_div

Overview:
Sequential restoring divider. It is the inverse companion to pes_seq_mul and uses the same load/valid handshake. On a load pulse it captures an unsigned dividend and divisor, then produces one quotient bit per clock. It presents the quotient, remainder and a divide-by-zero flag after a fixed latency, and sits beside pes_seq_mul in the arithmetic datapath.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset (0 = reset)
load  input  1  start request; operands sampled on the rising edge where load=1
a  input  WIDTH  dividend (unsigned)
b  input  WIDTH  divisor (unsigned)
q  output  WIDTH  quotient, registered
r  output  WIDTH  remainder, registered
valid  output  1  q/r/dbz hold a completed result
busy  output  1  division in progress
dbz  output  1  last completed division had b=0

Behaviour:
- Reset: rst=0 forces state IDLE immediately, regardless of clk. q=0, r=0, valid=0, busy=0, dbz=0, and the internal counter and working registers are 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on load=1.
  - RUN -> DONE when the counter reaches WIDTH-1 and that step completes.
  - DONE -> RUN on load=1.
  - Otherwise each state holds.
- Load edge (cycle N):
  - Latch dividend into shift register D and divisor into B.
  - Clear partial remainder P (WIDTH+1 bits, to hold the borrow).
  - Counter = 0, busy=1, valid=0.
  - q, r and dbz keep their previous values until overwritten.
- Each RUN cycle (edges N+1 .. N+WIDTH):
  - T = {P[WIDTH-1:0], D[MSB]}.
  - If T >= B: P = T - B and shift 1 into D's LSB. Else: P = T and shift 0.
  - Counter increments.
- Final step (edge N+WIDTH):
  - q = quotient bits, r = P[WIDTH-1:0], dbz = (B==0).
  - valid=1, busy=0, state=DONE.
  - Latency: valid is high after the WIDTH-th edge following the load edge (8 cycles for WIDTH=8).
- valid is a level, not a pulse: it stays high in DONE until the next accepted load or reset.
- Divide by zero: no special datapath. The algorithm naturally yields q = all ones and r = a. dbz=1 with the same latency.
- Load while busy (RUN): the in-flight operation is aborted and the new operands are latched. Full latency restarts from that edge; no result of the aborted operation is ever presented.
- load held high for several cycles: re-latches every cycle, so the result appears WIDTH edges after the last load-high edge.
- a and b are ignored when load=0.
- Reset asserted mid-operation: immediate return to reset values; no partial result is visible.
- Invariant: whenever valid=1 and dbz=0, a = q*b + r and r < b.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package pes_arith_pkg:
  - state enum (IDLE, RUN, DONE)
  - default WIDTH constant
  - counter width constant, clog2(WIDTH)
- One natural sub-module: pes_div_step, a combinational single-step compare/subtract returning the next P and the quotient bit. It is instantiated once and reused each cycle.
- Everything else (FSM, counter, shift registers, output registers) stays in pes_seq_div.

Test Plan:
- Reset, then load a=255 b=255 -> after 8 cycles valid=1, q=1, r=0, dbz=0; valid stays high until the next load.
- Load a=200 b=7 -> busy high for 8 cycles, then q=28, r=4; load a=5 b=25 -> q=0, r=5.
- Load a=128 b=0 -> q=255, r=128, dbz=1, same 8-cycle latency; a following load a=80 b=10 -> q=8, r=0, dbz=0.
- Load a=100 b=3, then at cycle 3 load a=36 b=36 -> valid rises 8 cycles after the second load with q=1, r=0; q=33, r=1 never appears.
- Load a=11 b=33, drive rst=0 at cycle 4 between clock edges -> outputs go to 0 and busy=0 immediately, with no clock; after release, valid stays 0 until a new load.
- Random sweep of 1000 (a,b) pairs, WIDTH=8 and WIDTH=16 -> every result satisfies a = q*b + r with r < b, or the dbz rule when b=0.
